// File: rtl/irq_gen_pkg.sv
// Shared constants and types for the periodic/software interrupt generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package irq_gen_pkg;

    // Default build: six channels driving HWInt[7:2], 32-bit periods,
    // core held in reset for four cycles after release.
    localparam int NCH_DEF        = 6;
    localparam int CW_DEF         = 32;
    localparam int RST_CYCLES_DEF = 4;

    // Single-bit flags of one channel. Period and count live beside this
    // struct in irq_chan because their width follows the CW parameter.
    typedef struct packed {
        logic en;       // unmasks the channel's irq output
        logic pending;  // latched event, cleared only by ack or reset
    } chan_flags_t;

    // Core reset sequencer: hold the core in reset, then let it run.
    typedef enum logic {
        SEQ_HOLD = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_t;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_chan.sv
// One interrupt channel: programmable period counter plus sticky pending flag.
// Latency: an event sets pending on the edge it occurs; irq follows pending & en with no extra delay.
// Backpressure: none; ack and events are sampled every cycle, a set beats an ack.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   run                 1 when the core is out of reset; freezes counter and gates sw/ack
//   cfg_we              decoded write strobe for this channel
//   cfg_period, cfg_en  value loaded on a write (period 0 disables the periodic source)
//   sw_irq, irq_ack     per-channel software trigger / pending clear
//   irq                 pending & en
module irq_chan
    import irq_gen_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          run,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_period,
    input  logic          cfg_en,
    input  logic          sw_irq,
    input  logic          irq_ack,
    output logic          irq
);

    logic [CW-1:0] period;
    logic [CW-1:0] count;
    chan_flags_t   flags;

    logic period_on;
    logic wrap;
    logic set_pend;
    logic clr_pend;

    assign period_on = (period != '0);

    // A write restarts the count from zero, so it also suppresses any wrap
    // that the old period would have produced on the same edge.
    assign wrap     = run && !cfg_we && period_on && (count == (period - CW'(1)));
    assign set_pend = wrap || (run && sw_irq);
    assign clr_pend = run && irq_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= '0;
            count  <= '0;
            flags  <= '0;
        end else begin
            if (cfg_we) begin
                period   <= cfg_period;
                flags.en <= cfg_en;
                count    <= '0;
            end else if (run && period_on) begin
                count <= wrap ? '0 : (count + CW'(1));
            end

            // Set has priority so an ack racing a new event cannot lose it.
            if (set_pend) begin
                flags.pending <= 1'b1;
            end else if (clr_pend) begin
                flags.pending <= 1'b0;
            end
        end
    end

    assign irq = flags.pending & flags.en;

endmodule

// File: rtl/irq_gen.sv
// Interrupt generator: NCH periodic/software channels plus a core reset sequencer.
// Latency: config/sw/ack act on the next edge; irq and irq_any are combinational from registers.
// Backpressure: none; every input is sampled every cycle, out-of-range config writes are dropped.
//
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   cfg_we, cfg_ch, cfg_period, cfg_en    channel configuration write
//   sw_irq[NCH], irq_ack[NCH]             per-channel trigger / pending clear
//   cpu_reset                             active-high reset for the driven core
//   irq[NCH], irq_any                     level interrupt requests and their OR
module irq_gen
    import irq_gen_pkg::*;
#(
    parameter int NCH        = NCH_DEF,
    parameter int CW         = CW_DEF,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfg_we,
    input  logic [clog2_min1(NCH)-1:0]  cfg_ch,
    input  logic [CW-1:0]               cfg_period,
    input  logic                        cfg_en,
    input  logic [NCH-1:0]              sw_irq,
    input  logic [NCH-1:0]              irq_ack,
    output logic                        cpu_reset,
    output logic [NCH-1:0]              irq,
    output logic                        irq_any
);

    localparam int CHW = clog2_min1(NCH);
    localparam int RCW = clog2_min1(RST_CYCLES + 1);

    seq_state_t     seq_state;
    logic [RCW-1:0] rst_cnt;
    logic           run;

    // cpu_reset stays high for RST_CYCLES edges after release; a count of
    // 0 or 1 both release on the first edge since the reset itself covers
    // the time before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_state <= SEQ_HOLD;
            rst_cnt   <= RCW'(RST_CYCLES);
            cpu_reset <= 1'b1;
        end else begin
            case (seq_state)
                SEQ_HOLD: begin
                    if (rst_cnt <= RCW'(1)) begin
                        seq_state <= SEQ_RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - RCW'(1);
                    end
                end
                SEQ_RUN: begin
                    cpu_reset <= 1'b0;
                end
                default: begin
                    seq_state <= SEQ_HOLD;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

    assign run = !cpu_reset;

    // Channel index decode: indices at or above NCH match no channel.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        irq_chan #(
            .CW (CW)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .run        (run),
            .cfg_we     (cfg_we && (cfg_ch == CHW'(g))),
            .cfg_period (cfg_period),
            .cfg_en     (cfg_en),
            .sw_irq     (sw_irq[g]),
            .irq_ack    (irq_ack[g]),
            .irq        (irq[g])
        );
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_irq_gen.sv
`timescale 1ns/100ps
module tb_irq_gen;

    localparam int NCH        = 6;
    localparam int CW         = 32;
    localparam int RST_CYCLES = 4;
    localparam int RL         = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int CHW        = $clog2(NCH);

    logic           clk        = 1'b1;
    logic           reset_n    = 1'b1;
    logic           cfg_we     = 1'b0;
    logic [CHW-1:0] cfg_ch     = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic           cfg_en     = 1'b0;
    logic [NCH-1:0] sw_irq     = '0;
    logic [NCH-1:0] irq_ack    = '0;
    logic           cpu_reset;
    logic [NCH-1:0] irq;
    logic           irq_any;

    irq_gen #(
        .NCH        (NCH),
        .CW         (CW),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .sw_irq     (sw_irq),
        .irq_ack    (irq_ack),
        .cpu_reset  (cpu_reset),
        .irq        (irq),
        .irq_any    (irq_any)
    );

    // Posedges at 4,8,12,...; inputs change on negedges, outputs sampled 1ns after posedge.
    always #2 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model.
    int unsigned m_period [NCH];
    int unsigned m_cnt    [NCH];
    bit          m_en     [NCH];
    bit          m_pend   [NCH];
    bit          m_rst;
    int          rel_edges;

    typedef struct {
        logic [NCH-1:0] irq;
        logic           any;
        logic           rst;
    } exp_t;
    exp_t sb[$];

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = 0;
            m_cnt[i]    = 0;
            m_en[i]     = 0;
            m_pend[i]   = 0;
        end
        m_rst     = 1;
        rel_edges = 0;
    endtask

    function automatic logic [NCH-1:0] m_irq();
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_pend[i] & m_en[i];
        return v;
    endfunction

    // Advance model by one edge using the currently driven inputs, push the
    // expectation, then let the DUT take the edge and compare.
    task automatic cycle();
        bit   run;
        bit   ev;
        exp_t e;
        run = !m_rst;
        for (int i = 0; i < NCH; i++) begin
            ev = 0;
            if (cfg_we && int'(cfg_ch) == i) begin
                m_period[i] = cfg_period;
                m_en[i]     = cfg_en;
                m_cnt[i]    = 0;
            end else if (run && m_period[i] != 0) begin
                if (m_cnt[i] == m_period[i] - 1) begin
                    m_cnt[i] = 0;
                    ev = 1;
                end else begin
                    m_cnt[i]++;
                end
            end
            if (ev || (run && sw_irq[i])) m_pend[i] = 1;
            else if (run && irq_ack[i])   m_pend[i] = 0;
        end
        rel_edges++;
        m_rst = (rel_edges < RL);
        e.irq = m_irq();
        e.any = |e.irq;
        e.rst = m_rst;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("irq",       32'(irq),       32'(e.irq));
        chk("irq_any",   32'(irq_any),   32'(e.any));
        chk("cpu_reset", 32'(cpu_reset), 32'(e.rst));
        @(negedge clk);
        cfg_we  = 1'b0;
        sw_irq  = '0;
        irq_ack = '0;
    endtask

    task automatic wr(input int ch, input int unsigned per, input bit en);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = CW'(per);
        cfg_en     = en;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        m_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_irq",       32'(irq),       32'd0);
        chk("rst_irq_any",   32'(irq_any),   32'd0);
        #8 reset_n = 1'b1;   // t=10ns, a negedge

        // Release sequence; sw/ack during cpu_reset must be ignored.
        for (int i = 0; i < 4; i++) begin
            if (i == 1) sw_irq  = '1;
            if (i == 2) irq_ack = '1;
            cycle();
            chk("rst_hold", 32'(cpu_reset), 32'(i < 3));
        end

        // ch2 period 5: irq[2] rises on the 5th edge after the write.
        wr(2, 5, 1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            chk("ch2_rise", 32'(irq[2]), 32'(k == 5));
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("ch2_hold", 32'(irq[2]), 32'd1);
            chk("ch2_any",  32'(irq_any), 32'd1);
        end

        // ch0 period 3: ack on a wrap edge loses, ack on a plain edge clears.
        wr(0, 3, 1);
        for (int k = 1; k <= 7; k++) begin
            if (k == 6 || k == 7) irq_ack[0] = 1'b1;
            cycle();
            chk("ch0_ack", 32'(irq[0]), 32'(k >= 3 && k <= 6));
        end

        // Masking keeps pending; unmasking re-exposes it.
        wr(2, 5, 0);
        chk("ch2_mask",   32'(irq[2]), 32'd0);
        wr(2, 5, 1);
        chk("ch2_unmask", 32'(irq[2]), 32'd1);

        // ch5 sw trigger while disabled, then enable with period 0.
        wr(5, 0, 0);
        sw_irq[5] = 1'b1;
        cycle();
        chk("ch5_sw_masked", 32'(irq[5]), 32'd0);
        wr(5, 0, 1);
        chk("ch5_enable", 32'(irq[5]), 32'd1);

        // ch3 period 1 fires every edge, so acking every edge never clears it.
        wr(3, 1, 1);
        for (int k = 0; k < 3; k++) begin
            irq_ack[3] = 1'b1;
            cycle();
            chk("ch3_p1", 32'(irq[3]), 32'd1);
        end
        wr(3, 0, 0);
        chk("ch3_off", 32'(irq[3]), 32'd0);

        // ch1 period 8: a rewrite restarts the count.
        wr(1, 8, 1);
        for (int k = 0; k < 6; k++) cycle();
        wr(1, 8, 1);
        for (int k = 1; k <= 8; k++) begin
            cycle();
            chk("ch1_restart", 32'(irq[1]), 32'(k == 8));
        end
        wr(7, 1, 0);
        chk("bad_ch", 32'(irq), 32'(6'b100111));
        irq_ack[1] = 1'b1;
        cycle();
        chk("pre_reset", 32'(irq), 32'(6'b100101));

        // Asynchronous reset mid-operation, checked before the next edge.
        #1 reset_n = 1'b0;
        #0.5;
        chk("async_irq",       32'(irq),       32'd0);
        chk("async_irq_any",   32'(irq_any),   32'd0);
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        m_reset();
        @(posedge clk);
        #1;
        chk("held_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rst2_hold", 32'(cpu_reset), 32'(i < 3));
        end

        // Configuration is gone: sw trigger stays masked until re-enabled.
        sw_irq[2] = 1'b1;
        cycle();
        chk("cfg_lost", 32'(irq), 32'd0);
        wr(2, 0, 1);
        chk("cfg_reprog", 32'(irq[2]), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg_we     = 1'b1;
                cfg_ch     = CHW'($urandom_range(0, 7));
                cfg_period = CW'($urandom_range(0, 6));
                cfg_en     = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) sw_irq = NCH'($urandom);
            if ($urandom_range(0, 1) == 0) irq_ack = NCH'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/irq_gen.md
IRQ_GEN -- requirements
Module: irq_gen

Interface
REQ-001 Parameter NCH, default 6, SHALL set the number of interrupt channels (maps to HWInt[7:2]).
REQ-002 Parameter CW, default 32, SHALL set the period/counter width in bits.
REQ-003 Parameter RST_CYCLES, default 4, SHALL set how many clk rising edges cpu_reset is held after reset_n release.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cfg_we  in  1  writes the configuration of channel cfg_ch this cycle.
REQ-007 cfg_ch  in  $clog2(NCH)  target channel of the write.
REQ-008 cfg_period  in  CW  period in cycles; 0 disables the periodic source.
REQ-009 cfg_en  in  1  channel enable (unmasks irq output).
REQ-010 sw_irq  in  NCH  per-channel one-cycle software trigger.
REQ-011 irq_ack  in  NCH  per-channel pending clear.
REQ-012 cpu_reset  out  1  active-high reset for the core under drive.
REQ-013 irq  out  NCH  per-channel interrupt request, level.
REQ-014 irq_any  out  1  OR of irq.

Function
REQ-015 Each channel SHALL hold period (CW), en (1), count (CW), pending (1) registers.
REQ-016 A cfg_we with cfg_ch < NCH SHALL load period and en and clear count to 0 on the same edge; cfg_ch >= NCH SHALL be ignored.
REQ-017 While cpu_reset=0 and period!=0, count SHALL increment each cycle, and when count==period-1 it SHALL wrap to 0 and set pending on that edge.
REQ-018 period==1 SHALL set pending every cycle; period==0 SHALL hold count at 0 and generate no periodic events.
REQ-019 sw_irq[i]=1 SHALL set pending[i] on the next edge regardless of en or period.
REQ-020 irq_ack[i]=1 SHALL clear pending[i] on the next edge unless a periodic or sw event for channel i occurs on the same edge, in which case pending SHALL remain 1 (set wins).
REQ-021 irq[i] SHALL equal pending[i] & en[i] combinationally from registers; latency from event edge to irq high is zero cycles after that edge.
REQ-022 Clearing en SHALL drop irq[i] but SHALL retain pending[i]; re-enabling SHALL re-expose it.
REQ-023 Counters SHALL be frozen at 0 while cpu_reset=1; sw_irq and irq_ack SHALL be ignored while cpu_reset=1.
REQ-024 cpu_reset SHALL be 1 while reset_n=0 and for exactly RST_CYCLES rising edges after reset_n rises, then 0 until next reset.
REQ-025 RST_CYCLES==0 SHALL make cpu_reset deassert on the first rising edge after release.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear period, en, count, pending to 0, force irq=0, irq_any=0, cpu_reset=1, and reload the release counter.
REQ-027 Reset asserted mid-period SHALL discard all configuration; software must reprogram after release.

Structure
REQ-028 Package irq_gen_pkg SHALL hold default NCH, CW, RST_CYCLES constants and the channel-register struct typedef.
REQ-029 One sub-module irq_chan (period/count/pending/en for one channel) SHALL be instantiated NCH times via generate; reset sequencer stays in irq_gen.
REQ-030 Target size 120-400 RTL lines; no latches, no combinational loops.

Verification
REQ-031 Release reset_n at t=10ns, RST_CYCLES=4, clk period 4ns -> cpu_reset falls after the 4th rising edge post-release, irq=0 throughout.
REQ-032 Write ch2 period=5 en=1, no ack -> irq[2] rises 5 cycles after write, stays high; irq_any=1.
REQ-033 ch0 period=3 en=1, assert irq_ack[0] on the same edge as the wrap -> pending[0] stays 1 (set wins); ack on a non-wrap edge -> irq[0] low next cycle.
REQ-034 ch5 period=0 en=0, pulse sw_irq[5] -> irq[5]=0; then write en=1 period=0 -> irq[5]=1 immediately after write edge.
REQ-035 ch1 period=8 running 6 cycles, rewrite period=8 -> next event 8 cycles after rewrite; cfg_ch=7 write -> no state change.
REQ-036 Assert reset_n=0 mid-operation with irq=6'b100101 -> irq=0, cpu_reset=1 asynchronously, before the next clk edge.
